// File: rtl/jt900h_busarb_pkg.sv
// ============================================================================
// jt900h_busarb_pkg
// Shared encodings, owner IDs, FSM states and small helpers for the bus arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package jt900h_busarb_pkg;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_W = 2'b01;
  localparam logic [1:0] LEN_L = 2'b10;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_WAIT = 3'd2,
    ST_CAPT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // The reserved encoding 2'b11 behaves as a 4-byte access.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    logic [2:0] w_nb;
    case (len)
      LEN_B:   w_nb = 3'd1;
      LEN_W:   w_nb = 3'd2;
      default: w_nb = 3'd4;
    endcase
    return w_nb;
  endfunction

  function automatic logic [1:0] reads_needed(input logic odd, input logic [2:0] nbytes);
    logic [3:0] w_sum;
    w_sum = {3'b000, odd} + {1'b0, nbytes} + 4'd1;
    return w_sum[2:1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/jt900h_busarb_if.sv
// ============================================================================
// jt900h_busarb_if
// Requester handshakes, result bus and RAM read port of the bus arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface jt900h_busarb_if;

  logic        fetch_req;
  logic [23:0] fetch_addr;
  logic [1:0]  fetch_len;
  logic        fetch_rdy;

  logic        data_req;
  logic [23:0] data_addr;
  logic [1:0]  data_len;
  logic        data_rdy;

  logic [31:0] dout;
  logic        busy;

  logic [23:0] ram_addr;
  logic [15:0] ram_dout;

  modport slave (
    input  fetch_req, fetch_addr, fetch_len,
    input  data_req, data_addr, data_len,
    input  ram_dout,
    output fetch_rdy, data_rdy, dout, busy, ram_addr
  );

  modport master (
    output fetch_req, fetch_addr, fetch_len,
    output data_req, data_addr, data_len,
    output ram_dout,
    input  fetch_rdy, data_rdy, dout, busy, ram_addr
  );

endinterface

`default_nettype wire

// File: rtl/jt900h_busarb_pack.sv
// ============================================================================
// jt900h_busarb_pack
// Byte-lane assembler: places incoming halfword bytes at the running byte count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module jt900h_busarb_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cen,
  input  logic        i_start,
  input  logic        i_odd,
  input  logic [2:0]  i_nbytes,
  input  logic        i_capt,
  input  logic [15:0] i_hw,
  output logic [31:0] o_next
);

  logic [31:0] r_bytes;
  logic [2:0]  r_cnt;
  logic [2:0]  r_nb;
  logic        r_skip;

  logic [31:0] w_bytes;
  logic [2:0]  w_cnt;

  // Lanes beyond the requested size are never written, so they stay zero.
  always_comb begin
    w_bytes = r_bytes;
    w_cnt   = r_cnt;
    if (!r_skip && (w_cnt < r_nb)) begin
      w_bytes[{w_cnt[1:0], 3'b000} +: 8] = i_hw[7:0];
      w_cnt = w_cnt + 3'd1;
    end
    if (w_cnt < r_nb) begin
      w_bytes[{w_cnt[1:0], 3'b000} +: 8] = i_hw[15:8];
      w_cnt = w_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bytes <= '0;
      r_cnt   <= '0;
      r_nb    <= '0;
      r_skip  <= 1'b0;
    end else if (i_cen) begin
      if (i_start) begin
        r_bytes <= '0;
        r_cnt   <= '0;
        r_nb    <= i_nbytes;
        r_skip  <= i_odd;
      end else if (i_capt) begin
        r_bytes <= w_bytes;
        r_cnt   <= w_cnt;
        r_skip  <= 1'b0;
      end
    end
  end

  assign o_next = w_bytes;

endmodule

`default_nettype wire

// File: rtl/jt900h_busarb.sv
// ============================================================================
// jt900h_busarb
// Fetch/data arbiter and halfword read sequencer for the shared RAM read port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module jt900h_busarb
  import jt900h_busarb_pkg::*;
#(
  parameter int RDLAT   = 1,
  parameter int MAXDATA = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  jt900h_busarb_if.slave bus
);

  localparam int              SW          = (MAXDATA < 1) ? 1 : $clog2(MAXDATA + 1);
  localparam logic [SW-1:0]   c_max_cnt   = SW'(MAXDATA);
  localparam logic [1:0]      c_wait_last = 2'(RDLAT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  owner_t        r_owner;
  logic [23:0]   r_cur;
  logic [23:0]   r_ram_addr;
  logic [1:0]    r_left;
  logic [1:0]    r_wcnt;
  logic [SW-1:0] r_starve;
  logic [31:0]   r_dout;
  logic          r_fetch_rdy;
  logic          r_data_rdy;
  logic          r_busy;

  logic          w_gnt_fetch;
  logic          w_gnt_data;
  logic          w_grant;
  logic          w_capt;
  logic          w_last;
  logic [23:0]   w_gnt_addr;
  logic [1:0]    w_gnt_len;
  logic [2:0]    w_gnt_nb;
  logic [31:0]   w_pack;

  assign w_grant    = w_gnt_fetch | w_gnt_data;
  assign w_gnt_addr = w_gnt_fetch ? bus.fetch_addr : bus.data_addr;
  assign w_gnt_len  = w_gnt_fetch ? bus.fetch_len  : bus.data_len;
  assign w_gnt_nb   = len_bytes(w_gnt_len);
  assign w_last     = (r_left == 2'd1);

  // Data has priority unless fetch has already waited MAXDATA data grants.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_fetch = 1'b0;
    w_gnt_data  = 1'b0;
    w_capt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.fetch_req && (!bus.data_req || (r_starve == c_max_cnt))) begin
          w_gnt_fetch = 1'b1;
          w_state_nxt = ST_ADDR;
        end else if (bus.data_req) begin
          w_gnt_data  = 1'b1;
          w_state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (r_wcnt == c_wait_last) begin
          w_state_nxt = ST_CAPT;
        end
      end
      ST_CAPT: begin
        w_capt      = 1'b1;
        w_state_nxt = w_last ? ST_DONE : ST_ADDR;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (cen) begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= OWN_FETCH;
      r_cur       <= '0;
      r_ram_addr  <= '0;
      r_left      <= '0;
      r_wcnt      <= '0;
      r_dout      <= '0;
      r_fetch_rdy <= 1'b0;
      r_data_rdy  <= 1'b0;
      r_busy      <= 1'b0;
    end else if (cen) begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_owner <= w_gnt_fetch ? OWN_FETCH : OWN_DATA;
            r_cur   <= w_gnt_addr;
            r_left  <= reads_needed(w_gnt_addr[0], w_gnt_nb);
            r_busy  <= 1'b1;
          end
        end
        ST_ADDR: begin
          r_ram_addr <= {r_cur[23:1], 1'b0};
          r_wcnt     <= '0;
        end
        ST_WAIT: r_wcnt <= r_wcnt + 2'd1;
        ST_CAPT: begin
          // 24-bit add wraps naturally past the top of the address space.
          r_cur  <= r_cur + 24'd2;
          r_left <= r_left - 2'd1;
          if (w_last) begin
            r_dout      <= w_pack;
            r_fetch_rdy <= (r_owner == OWN_FETCH);
            r_data_rdy  <= (r_owner == OWN_DATA);
          end
        end
        ST_DONE: begin
          r_fetch_rdy <= 1'b0;
          r_data_rdy  <= 1'b0;
          r_busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (cen) begin
      if (!bus.fetch_req || w_gnt_fetch) begin
        r_starve <= '0;
      end else if (w_gnt_data && (r_starve != c_max_cnt)) begin
        r_starve <= r_starve + SW'(1);
      end
    end
  end

  jt900h_busarb_pack u_pack (
    .clk      (clk),
    .rst      (rst),
    .i_cen    (cen),
    .i_start  (w_grant),
    .i_odd    (w_gnt_addr[0]),
    .i_nbytes (w_gnt_nb),
    .i_capt   (w_capt),
    .i_hw     (bus.ram_dout),
    .o_next   (w_pack)
  );

  assign bus.fetch_rdy = r_fetch_rdy;
  assign bus.data_rdy  = r_data_rdy;
  assign bus.dout      = r_dout;
  assign bus.busy      = r_busy;
  assign bus.ram_addr  = r_ram_addr;

endmodule

`default_nettype wire

// File: tb/tb_jt900h_busarb.sv
// ============================================================================
// tb_jt900h_busarb
// Scoreboard bench for the fetch/data bus arbiter (RDLAT=1 and RDLAT=2 copies).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_jt900h_busarb;

  typedef struct packed {
    logic        own;
    logic [31:0] val;
  } exp_t;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic cen1 = 1'b1;
  logic cen2 = 1'b1;
  logic tog2 = 1'b0;

  int checks = 0;
  int errors = 0;

  exp_t        q1[$];
  exp_t        q2[$];
  logic [23:0] alog[$];
  logic [23:0] alast = 24'h0;

  logic [7:0]  mem [0:4095];
  logic [15:0] p1  = 16'h0;
  logic [15:0] p2a = 16'h0;
  logic [15:0] p2b = 16'h0;

  always #5 clk = ~clk;

  jt900h_busarb_if bus1 ();
  jt900h_busarb_if bus2 ();

  jt900h_busarb #(.RDLAT(1), .MAXDATA(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .cen (cen1),
    .bus (bus1)
  );

  jt900h_busarb #(.RDLAT(2), .MAXDATA(4)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .cen (cen2),
    .bus (bus2)
  );

  function automatic logic [15:0] rdhw(input logic [23:0] a);
    return {mem[{a[11:1], 1'b1}], mem[{a[11:1], 1'b0}]};
  endfunction

  // Reference: nbytes consecutive bytes from addr, wrapping at 2^24.
  function automatic logic [31:0] model(input logic [23:0] a, input logic [1:0] len);
    int          nb;
    logic [31:0] r;
    logic [23:0] ai;
    nb = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    r  = 32'h0;
    for (int i = 0; i < nb; i++) begin
      ai = a + 24'(i);
      r[8*i +: 8] = mem[ai[11:0]];
    end
    return r;
  endfunction

  // RAM models with RDLAT cen-cycle read pipelines.
  always @(posedge clk) if (cen1) p1 <= rdhw(bus1.ram_addr);
  always @(posedge clk) if (cen2) begin
    p2a <= rdhw(bus2.ram_addr);
    p2b <= p2a;
  end
  assign bus1.ram_dout = p1;
  assign bus2.ram_dout = p2b;

  initial forever begin
    @(posedge clk);
    #1;
    cen2 = tog2 ? ~cen2 : 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (bus1.ram_addr !== alast) begin
      alog.push_back(bus1.ram_addr);
      alast = bus1.ram_addr;
    end
  end

  initial forever begin : mon1
    exp_t e;
    @(negedge clk);
    if (cen1 && (bus1.fetch_rdy || bus1.data_rdy)) begin
      checks++;
      if (bus1.fetch_rdy && bus1.data_rdy) begin
        errors++;
        $display("FAIL dut1_both_rdy: fetch_rdy=%b data_rdy=%b, expected one-hot", bus1.fetch_rdy, bus1.data_rdy);
      end else if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_unexpected_rdy: data_rdy=%b dout=%h, expected no completion", bus1.data_rdy, bus1.dout);
      end else begin
        e = q1.pop_front();
        if (bus1.data_rdy !== e.own || bus1.dout !== e.val) begin
          errors++;
          $display("FAIL dut1_result: owner=%b dout=%h, expected owner=%b dout=%h", bus1.data_rdy, bus1.dout, e.own, e.val);
        end
      end
    end
  end

  initial forever begin : mon2
    exp_t e;
    @(negedge clk);
    if (cen2 && (bus2.fetch_rdy || bus2.data_rdy)) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL dut2_unexpected_rdy: data_rdy=%b dout=%h, expected no completion", bus2.data_rdy, bus2.dout);
      end else begin
        e = q2.pop_front();
        if (bus2.data_rdy !== e.own || bus2.dout !== e.val) begin
          errors++;
          $display("FAIL dut2_result: owner=%b dout=%h, expected owner=%b dout=%h", bus2.data_rdy, bus2.dout, e.own, e.val);
        end
      end
    end
  end

  task automatic wait_rdy(input int which, input bit own, output int cens, output int clks, output bit ok);
    logic c;
    logic r;
    cens = 0;
    clks = 0;
    ok   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      c = (which == 1) ? cen1 : cen2;
      clks++;
      if (c) cens++;
      #2;
      if (which == 1) r = own ? bus1.data_rdy : bus1.fetch_rdy;
      else            r = own ? bus2.data_rdy : bus2.fetch_rdy;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout: dut%0d owner=%b no rdy after %0d clocks, expected rdy", which, own, clks);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (bus1.ram_addr !== 24'h0) begin errors++; $display("FAIL reset_ram_addr: got %h, expected 000000", bus1.ram_addr); end
    checks++; if (bus1.dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h, expected 00000000", bus1.dout); end
    checks++; if (bus1.fetch_rdy !== 1'b0 || bus1.data_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b%b, expected 00", bus1.fetch_rdy, bus1.data_rdy); end
    checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", bus1.busy); end
    rst = 1'b0;
  endtask

  task automatic test_fetch_word();
    int cens, clks;
    bit ok;
    mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
    @(posedge clk); #1;
    alog.delete();
    q1.push_back('{own: 1'b0, val: 32'h44332211});
    bus1.fetch_addr = 24'h000100; bus1.fetch_len = 2'b10; bus1.fetch_req = 1'b1;
    wait_rdy(1, 1'b0, cens, clks, ok);
    bus1.fetch_req = 1'b0;
    checks++; if (cens != 7) begin errors++; $display("FAIL fetch_latency: got %0d cen cycles, expected 7", cens); end
    checks++; if (alog.size() != 2 || alog[0] !== 24'h100 || alog[1] !== 24'h102) begin
      errors++; $display("FAIL fetch_reads: got %0d reads, expected 2 (000100,000102)", alog.size()); end
    @(posedge clk); #2;
    checks++; if (bus1.fetch_rdy !== 1'b0) begin errors++; $display("FAIL fetch_pulse: rdy still %b, expected 0", bus1.fetch_rdy); end
    checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL fetch_busy_after: got %b, expected 0", bus1.busy); end
  endtask

  task automatic test_data_odd();
    int cens, clks;
    bit ok;
    mem[12'h100] = 8'h00; mem[12'h101] = 8'hAA; mem[12'h102] = 8'hBB;
    mem[12'h103] = 8'hCC; mem[12'h104] = 8'hDD; mem[12'h105] = 8'hEE;
    @(posedge clk); #1;
    alog.delete();
    q1.push_back('{own: 1'b1, val: 32'hDDCCBBAA});
    bus1.data_addr = 24'h000101; bus1.data_len = 2'b10; bus1.data_req = 1'b1;
    wait_rdy(1, 1'b1, cens, clks, ok);
    bus1.data_req = 1'b0;
    checks++; if (cens != 10) begin errors++; $display("FAIL data_latency: got %0d cen cycles, expected 10", cens); end
    checks++; if (alog.size() != 3 || alog[0] !== 24'h100 || alog[1] !== 24'h102 || alog[2] !== 24'h104) begin
      errors++; $display("FAIL data_reads: got %0d reads, expected 3 (000100,000102,000104)", alog.size()); end
  endtask

  task automatic test_starvation();
    int nd;
    bit ok;
    mem[12'h200] = 8'h5A; mem[12'h201] = 8'hC3; mem[12'h300] = 8'h7E;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) q1.push_back('{own: 1'b1, val: model(24'h000200, 2'b01)});
    q1.push_back('{own: 1'b0, val: model(24'h000300, 2'b00)});
    bus1.data_addr  = 24'h000200; bus1.data_len  = 2'b01;
    bus1.fetch_addr = 24'h000300; bus1.fetch_len = 2'b00;
    bus1.data_req = 1'b1; bus1.fetch_req = 1'b1;
    nd = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (bus1.data_rdy) nd++;
      if (bus1.fetch_rdy) begin ok = 1'b1; break; end
    end
    bus1.data_req = 1'b0; bus1.fetch_req = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL starve_fetch: fetch_rdy=%b, expected fetch granted", ok); end
    checks++; if (nd != 4) begin errors++; $display("FAIL starve_count: got %0d data grants, expected 4", nd); end
    repeat (6) @(posedge clk);
    #2;
    checks++; if (bus1.busy !== 1'b0 || q1.size() != 0) begin
      errors++; $display("FAIL starve_drain: busy=%b pending=%0d, expected 0 and 0", bus1.busy, q1.size()); end
  endtask

  task automatic test_wrap();
    int cens, clks;
    bit ok;
    mem[12'hFFE] = 8'h99; mem[12'hFFF] = 8'h12; mem[12'h000] = 8'h34; mem[12'h001] = 8'h77;
    @(posedge clk); #1;
    alog.delete();
    q1.push_back('{own: 1'b1, val: 32'h00003412});
    bus1.data_addr = 24'hFFFFFF; bus1.data_len = 2'b01; bus1.data_req = 1'b1;
    wait_rdy(1, 1'b1, cens, clks, ok);
    bus1.data_req = 1'b0;
    checks++; if (alog.size() != 2 || alog[0] !== 24'hFFFFFE || alog[1] !== 24'h000000) begin
      errors++; $display("FAIL wrap_reads: got %0d reads, expected 2 (FFFFFE,000000)", alog.size()); end
  endtask

  task automatic test_reset_mid();
    int cens, clks;
    bit ok;
    bit seen;
    @(posedge clk); #1;
    bus1.data_addr = 24'h000101; bus1.data_len = 2'b10; bus1.data_req = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    checks++; if (bus1.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b, expected 1", bus1.busy); end
    rst = 1'b1;
    bus1.data_req = 1'b0;
    @(posedge clk); #2;
    checks++; if (bus1.busy !== 1'b0 || bus1.ram_addr !== 24'h0 || bus1.dout !== 32'h0 || bus1.fetch_rdy !== 1'b0 || bus1.data_rdy !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: busy=%b ram_addr=%h dout=%h rdy=%b%b, expected all 0",
                         bus1.busy, bus1.ram_addr, bus1.dout, bus1.fetch_rdy, bus1.data_rdy); end
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #2;
      if (bus1.fetch_rdy || bus1.data_rdy || bus1.busy) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midrst_quiet: activity=%b after reset, expected 0", seen); end
    mem[12'h100] = 8'h00; mem[12'h101] = 8'hAA;
    #1;
    q1.push_back('{own: 1'b0, val: model(24'h000100, 2'b01)});
    bus1.fetch_addr = 24'h000100; bus1.fetch_len = 2'b01; bus1.fetch_req = 1'b1;
    wait_rdy(1, 1'b0, cens, clks, ok);
    bus1.fetch_req = 1'b0;
    checks++; if (cens != 4) begin errors++; $display("FAIL min_latency: got %0d cen cycles, expected 4", cens); end
  endtask

  task automatic test_cen_toggle();
    int cens, clks;
    bit ok;
    mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
    for (int pass = 0; pass < 2; pass++) begin
      tog2 = (pass == 1);
      repeat (2) @(posedge clk);
      #1;
      q2.push_back('{own: 1'b0, val: 32'h44332211});
      bus2.fetch_addr = 24'h000100; bus2.fetch_len = 2'b10; bus2.fetch_req = 1'b1;
      wait_rdy(2, 1'b0, cens, clks, ok);
      bus2.fetch_req = 1'b0;
      checks++; if (cens != 9) begin errors++; $display("FAIL cen_cycles_pass%0d: got %0d, expected 9", pass, cens); end
      checks++; if ((pass == 0 && clks != 9) || (pass == 1 && (clks < 17 || clks > 18))) begin
        errors++; $display("FAIL clk_latency_pass%0d: got %0d clocks, expected %s", pass, clks, (pass == 0) ? "9" : "17..18"); end
      repeat (4) @(posedge clk);
    end
    tog2 = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    bus1.fetch_req = 1'b0; bus1.fetch_addr = 24'h0; bus1.fetch_len = 2'b00;
    bus1.data_req  = 1'b0; bus1.data_addr  = 24'h0; bus1.data_len  = 2'b00;
    bus2.fetch_req = 1'b0; bus2.fetch_addr = 24'h0; bus2.fetch_len = 2'b00;
    bus2.data_req  = 1'b0; bus2.data_addr  = 24'h0; bus2.data_len  = 2'b00;

    test_reset();
    test_fetch_word();
    test_data_odd();
    test_starvation();
    test_wrap();
    test_reset_mid();
    test_cen_toggle();

    repeat (4) @(posedge clk);
    #2;
    checks++; if (q1.size() != 0 || q2.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover: pending %0d/%0d, expected 0/0", q1.size(), q2.size()); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
